// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int M0     = 0;
  localparam int M1     = 1;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;
endpackage

// File: rtl/dmem_arb_sat_ctr.sv
// Saturating up-counter with clear, load and a compare against its limit.
module dmem_arb_sat_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  input  logic             inc_i,
  output logic             at_max_o
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over load, load wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i && (cnt_q < LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-master single-port data-memory arbiter: fixed m0 priority, starvation
// override for m1, and bounded m1 locked bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned BURST_MAX  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_gnt_o,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic              m1_lock_i,
  output logic              m1_gnt_o,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o
);
  // A one-beat burst limit means the granting beat is already the last one.
  localparam bit BURST_OK = (BURST_MAX > 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        gnt;
  logic              starve_max;
  logic              beat_last;
  logic              burst_enter;
  logic              m0_acc, m1_acc;
  logic              m0_ack_q, m1_ack_q;
  logic [DATA_W-1:0] m0_data_q, m1_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    gnt         = '0;
    state_d     = state_q;
    burst_enter = 1'b0;
    case (state_q)
      ARB: begin
        if (m1_req_i && starve_max) begin
          gnt[M1] = 1'b1;
        end else if (m0_req_i) begin
          gnt[M0] = 1'b1;
        end else if (m1_req_i) begin
          gnt[M1] = 1'b1;
        end
        if (gnt[M1] && m1_lock_i && BURST_OK) begin
          burst_enter = 1'b1;
          state_d     = BURST;
        end
      end
      BURST: begin
        gnt[M1] = m1_req_i;
        if (!m1_lock_i || !m1_req_i || beat_last) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  dmem_arb_sat_ctr #(.LIMIT(STARVE_MAX)) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (gnt[M1] | ~m1_req_i),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (m1_req_i & ~gnt[M1]),
    .at_max_o (starve_max)
  );

  // Counts accepted burst beats; its flag marks that the next accepted beat
  // is the one that reaches BURST_MAX and forces release.
  dmem_arb_sat_ctr #(.LIMIT(BURST_MAX - 1)) u_beat_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_d == ARB),
    .ld_i     (burst_enter),
    .ld_val_i (CNT_W'(1)),
    .inc_i    ((state_q == BURST) & gnt[M1]),
    .at_max_o (beat_last)
  );

  assign m0_gnt_o   = gnt[M0];
  assign m1_gnt_o   = gnt[M1];
  assign m0_acc     = m0_req_i & gnt[M0];
  assign m1_acc     = m1_req_i & gnt[M1];
  assign mem_addr_o = gnt[M1] ? m1_addr_i : m0_addr_i;
  assign mem_data_o = gnt[M1] ? m1_data_i : m0_data_i;
  assign mem_we_o   = gnt[M1] ? m1_we_i : (gnt[M0] & m0_we_i);
  assign busy_o     = (state_q == BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m0_data_q <= '0;
      m1_data_q <= '0;
    end else begin
      m0_ack_q <= m0_acc;
      m1_ack_q <= m1_acc;
      if (m0_acc && !m0_we_i) begin
        m0_data_q <= mem_data_i;
      end
      if (m1_acc && !m1_we_i) begin
        m1_data_q <= mem_data_i;
      end
    end
  end

  assign m0_ack_o  = m0_ack_q;
  assign m1_ack_o  = m1_ack_q;
  assign m0_data_o = m0_data_q;
  assign m1_data_o = m1_data_q;
endmodule
